// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds an LSB-first shifter.
// The bit period is latched at every pop, so mid-frame changes to clks_per_bit take effect on the next frame.
module uart_tx_fifo #(
  parameter int FifoDepth = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [14:0]                        clks_per_bit,
  input  logic                               tx_dv_i,
  input  logic [7:0]                         tx_byte_i,
  output logic                               tx_ready_o,
  output logic                               tx_o,
  output logic                               tx_busy_o,
  output logic                               tx_done_o,
  output logic [$clog2(FifoDepth+1)-1:0]     fifo_cnt_o,
  output logic [1:0]                         dbg_state
);

  localparam int AW = $clog2(FifoDepth);
  localparam int CW = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Handshake: a byte is accepted on every rising edge where tx_dv_i and tx_ready_o are both high;
  // tx_ready_o depends only on the registered count, never on tx_dv_i.
  state_t         state, state_nxt;
  logic [7:0]     mem [FifoDepth];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [7:0]     shift, shift_nxt;
  logic [14:0]    cpb, cpb_nxt;
  logic [14:0]    baud, baud_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic           push, pop, baud_last, have_byte;

  assign tx_ready_o = (count != CW'(FifoDepth));
  assign push       = tx_dv_i & tx_ready_o;
  assign have_byte  = (count != '0);
  assign baud_last  = (baud == cpb - 15'd1);
  assign fifo_cnt_o = count;
  assign tx_busy_o  = (state != IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    cpb_nxt     = cpb;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    tx_o        = 1'b1;
    tx_done_o   = 1'b0;
    case (state)
      IDLE: begin
        if (have_byte) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          cpb_nxt   = (clks_per_bit == 15'd0) ? 15'd1 : clks_per_bit;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (baud_last) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end else begin
          baud_nxt = baud + 15'd1;
        end
      end
      DATA: begin
        tx_o = shift[0];
        if (baud_last) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud + 15'd1;
        end
      end
      STOP: begin
        tx_done_o = baud_last;
        if (baud_last) begin
          baud_nxt = '0;
          // Chaining the next pop here keeps queued frames abutted with no idle cycle.
          if (have_byte) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            cpb_nxt   = (clks_per_bit == 15'd0) ? 15'd1 : clks_per_bit;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud + 15'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_byte_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      shift   <= '0;
      cpb     <= '0;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      cpb     <= cpb_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model checked every cycle, plus directed
// scenarios with hand-written expectations and a line decoder.
module tb_uart_tx_fifo;

  localparam int Depth = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] clks_per_bit = 15'd4;
  logic        tx_dv_i = 1'b0;
  logic [7:0]  tx_byte_i = 8'h00;
  logic        tx_ready_o, tx_o, tx_busy_o, tx_done_o;
  logic [2:0]  fifo_cnt_o;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  uart_tx_fifo #(.FifoDepth(Depth)) dut (
    .clock        (clock),
    .reset        (reset),
    .clks_per_bit (clks_per_bit),
    .tx_dv_i      (tx_dv_i),
    .tx_byte_i    (tx_byte_i),
    .tx_ready_o   (tx_ready_o),
    .tx_o         (tx_o),
    .tx_busy_o    (tx_busy_o),
    .tx_done_o    (tx_done_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .dbg_state    (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line model: bytes waiting, and one slot per future line cycle of the frame in progress.
  typedef struct packed { logic tx; logic done; } slot_t;
  logic [7:0] byte_q[$];
  slot_t      line_q[$];
  bit         model_live = 1'b0;
  int         cyc = 0;

  always @(posedge clock) begin : model_step
    bit         do_pop, do_push;
    int         c;
    logic [7:0] b;
    slot_t      s;
    cyc++;
    if (reset) begin
      byte_q.delete();
      line_q.delete();
      model_live = 1'b1;
    end else begin
      do_push = tx_dv_i && (byte_q.size() < Depth);
      do_pop  = (byte_q.size() > 0) && (line_q.size() <= 1);
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (do_pop) begin
        b = byte_q.pop_front();
        c = (clks_per_bit == 15'd0) ? 1 : int'(clks_per_bit);
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < c; j++) begin
            s.tx   = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
            s.done = (i == 9) && (j == c - 1);
            line_q.push_back(s);
          end
        end
      end
      if (do_push) byte_q.push_back(tx_byte_i);
    end
  end

  always @(negedge clock) begin
    if (model_live) begin
      chk("tx",    tx_o,       (line_q.size() > 0) ? line_q[0].tx : 1'b1);
      chk("busy",  tx_busy_o,  (line_q.size() > 0) ? 1'b1 : 1'b0);
      chk("done",  tx_done_o,  (line_q.size() > 0) ? line_q[0].done : 1'b0);
      chk("count", fifo_cnt_o, byte_q.size());
      chk("ready", tx_ready_o, (byte_q.size() < Depth) ? 1'b1 : 1'b0);
    end
  end

  // Monitor: frame start / done cycle stamps and a mid-bit sampling decoder.
  int         start_q[$];
  int         done_q[$];
  int         done_total = 0;
  bit         prev_busy = 1'b0;
  logic [7:0] rx_q[$];
  int         dec_cpb = 4;
  bit         dec_act = 1'b0;
  int         dec_pos = 0;
  logic       prev_tx = 1'b1;
  logic [7:0] dec_sh = 8'h00;

  always @(negedge clock) begin
    if (tx_busy_o === 1'b1 && !prev_busy) start_q.push_back(cyc);
    if (tx_done_o === 1'b1) begin
      done_q.push_back(cyc);
      done_total++;
    end
    prev_busy = (tx_busy_o === 1'b1);
    if (reset) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (prev_tx === 1'b1 && tx_o === 1'b0) begin
        dec_act = 1'b1;
        dec_pos = 0;
      end
    end else begin
      dec_pos++;
      if (dec_pos >= dec_cpb && dec_pos < 9 * dec_cpb && ((dec_pos - dec_cpb) % dec_cpb) == dec_cpb / 2)
        dec_sh[(dec_pos - dec_cpb) / dec_cpb] = tx_o;
      if (dec_pos == 9 * dec_cpb + dec_cpb / 2) begin
        rx_q.push_back(dec_sh);
        dec_act = 1'b0;
      end
    end
    prev_tx = reset ? 1'b1 : tx_o;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b);
    step();
    tx_dv_i = 1'b1;
    tx_byte_i = b;
    step();
    tx_dv_i = 1'b0;
  endtask

  task automatic push_two(input logic [7:0] b0, input logic [7:0] b1);
    step();
    tx_dv_i = 1'b1;
    tx_byte_i = b0;
    step();
    tx_byte_i = b1;
    step();
    tx_dv_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (tx_busy_o === 1'b0 && fifo_cnt_o === 3'd0) break;
      step();
    end
    chk(name, {tx_busy_o, fifo_cnt_o}, 4'h0);
    step();
    step();
  endtask

  logic a5_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int busy_cnt, done_cnt, done_at, done_at2, first_busy, last_busy, base;
    bit line_low;

    repeat (2) step();
    reset = 1'b0;
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_busy", tx_busy_o, 1'b0);
    chk("rst_done", tx_done_o, 1'b0);
    chk("rst_ready", tx_ready_o, 1'b1);
    chk("rst_count", fifo_cnt_o, 3'd0);

    // Single byte 0xA5 at four clocks per bit.
    clks_per_bit = 15'd4;
    dec_cpb = 4;
    push_one(8'hA5);
    chk("a5_count_after_push", fifo_cnt_o, 3'd1);
    chk("a5_tx_before_start", tx_o, 1'b1);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 1; i <= 44; i++) begin
      step();
      chk("a5_line", tx_o, (i <= 40) ? a5_bits[(i - 1) / 4] : 1'b1);
      if (tx_busy_o === 1'b1) busy_cnt++;
      if (tx_done_o === 1'b1) begin done_cnt++; done_at = i; end
    end
    chk("a5_busy_cycles", busy_cnt, 40);
    chk("a5_done_pulses", done_cnt, 1);
    chk("a5_done_cycle", done_at, 40);

    // Back-to-back 0x00 / 0xFF at three clocks per bit.
    clks_per_bit = 15'd3;
    dec_cpb = 3;
    rx_q.delete();
    push_two(8'h00, 8'hFF);
    busy_cnt = 0; done_cnt = 0; done_at = -1; done_at2 = -1; first_busy = -1; last_busy = -1;
    for (int i = 0; i < 70; i++) begin
      if (i > 0) step();
      if (tx_busy_o === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
        last_busy = i;
      end
      if (tx_done_o === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i; else done_at2 = i;
      end
      if (i == 29) chk("b2b_stop_end", tx_o, 1'b1);
      if (i == 30) chk("b2b_second_start", tx_o, 1'b0);
    end
    chk("b2b_busy_cycles", busy_cnt, 60);
    chk("b2b_busy_span", last_busy - first_busy + 1, 60);
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_done_gap", done_at2 - done_at, 30);
    chk("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 8'h00);
      chk("b2b_rx1", rx_q[1], 8'hFF);
    end

    // Fill past capacity at eight clocks per bit; the sixth byte is dropped.
    clks_per_bit = 15'd8;
    dec_cpb = 8;
    rx_q.delete();
    step();
    tx_dv_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tx_byte_i = 8'(k * 8'h11);
      step();
      if (k == 5) begin
        chk("full_count", fifo_cnt_o, 3'd4);
        chk("full_ready", tx_ready_o, 1'b0);
      end
    end
    tx_dv_i = 1'b0;
    chk("full_count_after_drop", fifo_cnt_o, 3'd4);
    wait_idle("full_drain");
    chk("full_ready_after", tx_ready_o, 1'b1);
    chk("full_rx_count", rx_q.size(), 5);
    if (rx_q.size() == 5)
      for (int k = 0; k < 5; k++) chk("full_rx_byte", rx_q[k], 8'((k + 1) * 8'h11));

    // Reset during data bit 3 of 0x3C with 0x5A queued.
    clks_per_bit = 15'd4;
    dec_cpb = 4;
    rx_q.delete();
    push_two(8'h3C, 8'h5A);
    repeat (17) step();
    reset = 1'b1;
    base = done_total;
    step();
    reset = 1'b0;
    chk("mid_rst_tx", tx_o, 1'b1);
    chk("mid_rst_count", fifo_cnt_o, 3'd0);
    chk("mid_rst_busy", tx_busy_o, 1'b0);
    chk("mid_rst_ready", tx_ready_o, 1'b1);
    line_low = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_o !== 1'b1) line_low = 1'b1;
    end
    chk("mid_rst_line_idle", line_low, 1'b0);
    chk("mid_rst_no_done", done_total - base, 0);
    chk("mid_rst_no_rx", rx_q.size(), 0);

    // Bit period latched at pop: 0xF0 at cpb=5, then 0x0F at cpb=2.
    clks_per_bit = 15'd5;
    start_q.delete();
    done_q.delete();
    push_one(8'hF0);
    repeat (10) step();
    clks_per_bit = 15'd2;
    push_one(8'h0F);
    wait_idle("latch_drain");
    chk("latch_frames_started", start_q.size(), 1);
    chk("latch_done_pulses", done_q.size(), 2);
    if (start_q.size() == 1 && done_q.size() == 2) begin
      chk("latch_first_len", done_q[0] - start_q[0] + 1, 50);
      chk("latch_second_len", done_q[1] - done_q[0], 20);
    end

    // Zero bit period behaves as one clock per bit.
    clks_per_bit = 15'd0;
    start_q.delete();
    done_q.delete();
    push_one(8'h55);
    wait_idle("zero_drain");
    chk("zero_done_pulses", done_q.size(), 1);
    if (start_q.size() == 1 && done_q.size() == 1)
      chk("zero_len", done_q[0] - start_q[0] + 1, 10);

    // Randomized traffic, bit periods and occasional resets against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) clks_per_bit = 15'($urandom_range(0, 5));
      tx_dv_i   = ($urandom_range(0, 2) == 0);
      tx_byte_i = 8'($urandom_range(0, 255));
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end
    tx_dv_i = 1'b0;
    reset = 1'b0;
    wait_idle("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter. It is the send-side counterpart to the SoC's `uart_rx` programmer path. Bytes written over a valid/ready handshake are queued in a small FIFO and shifted out LSB-first on `tx_o`, using the same runtime bit-period input convention as the receiver (`CLKS_PER_BIT`, 15 bits). It sits at SoC top level beside `uart_rx`, for boot-status/echo output to the host programmer.

## Interface
- `FifoDepth`, default 4: queue depth in bytes; must be a power of 2 and ≥2.
- `clock`  in  1  — single system clock; all logic on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `clks_per_bit`  in  15  — bit period in `clock` cycles. Sampled only at frame start. A value of 0 is treated as 1.
- `tx_dv_i`  in  1  — byte-valid strobe.
- `tx_byte_i`  in  8  — byte to send.
- `tx_ready_o`  out  1  — FIFO not full; a push happens on any edge where `tx_dv_i & tx_ready_o` is true.
- `tx_o`  out  1  — serial line; idles high.
- `tx_busy_o`  out  1  — high while a frame is on the line (START..STOP).
- `tx_done_o`  out  1  — one-cycle pulse in the last cycle of each stop bit.
- `fifo_cnt_o`  out  $clog2(FifoDepth+1)  — bytes queued, excluding the byte in flight.

## Operation
- **Reset values:** `tx_o`=1, `tx_busy_o`=0, `tx_done_o`=0, `tx_ready_o`=1, `fifo_cnt_o`=0. FSM=IDLE; FIFO pointers, bit counter and baud counter all 0.
- **FIFO:** circular buffer with wrapping read/write pointers; full when count==FifoDepth.
  - A push while full is dropped; the FIFO and count are unchanged.
  - There is no bypass from input to shifter. Every byte passes through the FIFO.
  - Push and pop in the same cycle leave the count unchanged.
  - `tx_ready_o` is derived from the registered count only, so it stays low in a full+pop cycle.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx_o`=1. If count>0, pop at this edge: load shift register, latch `cpb = max(clks_per_bit,1)`, clear baud counter, go to START.
  - **START:** `tx_o`=0 for `cpb` cycles, then go to DATA with bit index 0.
  - **DATA:** `tx_o`=shift[0] for `cpb` cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - **STOP:** `tx_o`=1 for `cpb` cycles. In the final cycle assert `tx_done_o`. In that same final cycle, if count>0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- **Busy flag:** `tx_busy_o` = (state != IDLE).
- **Baud counter:** counts 0..cpb-1 and wraps at cpb-1, which is the bit-advance event. A width of 15 bits is sufficient.
- **`clks_per_bit` changes mid-frame** do not affect the current frame; the new value applies from the next pop.
- **Reset asserted mid-frame:** aborts the frame and flushes the FIFO. `tx_o`=1 from the cycle after the reset edge. No `tx_done_o` is issued for the aborted byte.

## Timing
- **Push to start bit:** push at edge k; count=1 after k; pop at edge k+1; `tx_o` falls after edge k+1. Latency from push to start bit is 2 cycles.
- **Frame length:** exactly 10·cpb cycles from `tx_o` falling to the end of the stop bit.
- **Done pulse:** `tx_done_o` is high during cycle 10·cpb of the frame, counting the start cycle as cycle 1.
- **Back-to-back frames:** with the FIFO non-empty, consecutive frames abut. The stop bit of frame n is immediately followed by the start bit of frame n+1, giving N frames in 10·N·cpb cycles.
- **Outputs:** all are registered or decoded from registered state. There is no combinational path from `tx_dv_i` to any output.

## Test plan
- **Single byte:** cpb=4, push 0xA5 →
  - `tx_o` holds 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each for 4 cycles.
  - `tx_done_o` pulses once at frame cycle 40.
  - `tx_busy_o` is high for exactly 40 cycles.
- **Back-to-back:** cpb=3, push 0x00 then 0xFF on consecutive cycles → 60 contiguous cycles on the line with no idle between the stop and the second start. Two done pulses, 30 cycles apart.
- **Full/drop:** cpb=8, push 0x11 then 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles →
  - 0x11 goes in flight.
  - `fifo_cnt_o` reaches 4 and `tx_ready_o` drops.
  - 0x66 is dropped.
  - The line carries 0x11..0x55 in order; the count wraps cleanly back to 0.
- **Reset mid-frame:** cpb=4, queue 0x3C and 0x5A, then assert `reset` during data bit 3 of 0x3C →
  - next cycle: `tx_o`=1, count=0, busy=0, ready=1.
  - no `tx_done_o` pulse, and 0x5A is never sent.
- **Bit-period latch and zero clamp:**
  - Start 0xF0 at cpb=5, change to cpb=2 mid-frame, queue 0x0F → first frame lasts 50 cycles, second lasts 20.
  - cpb=0 → frame lasts 10 cycles.
